bubble_sort_engine: RTL and testbench
=====================================

# bubble_sort_engine

Self-contained, parametrised in-place bubble sort engine: an internal register-array memory of DEPTH words of DATA_WIDTH bits, loaded through a write port, sorted on `start` by an internal FSM with datapath, and read back through a combinational read port. It generalises the fixed 16-bit, 8-entry sort datapath/controller pair in three ways: configurable width and depth, a runtime ascending/descending mode, and early termination on a pass with no swaps. It also adds a saturating swap counter for performance observation.

## Interface
- DATA_WIDTH, 16, element width in bits.
- DEPTH, 8, number of elements; legal range 2..256.
- ADDR_WIDTH, 3, address width; must equal ceil(log2(DEPTH)).
- CNT_WIDTH, 16, width of the swap counter.

- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- wr_en  input  1  load strobe; writes wr_data to mem[wr_addr] when not busy.
- wr_addr  input  ADDR_WIDTH  load address.
- wr_data  input  DATA_WIDTH  load data.
- start  input  1  begin sort; sampled only when not busy.
- descending  input  1  0 = ascending, 1 = descending; latched on the accepted start.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  mem[rd_addr], combinational.
- busy  output  1  high while sorting.
- eoc  output  1  end of conversion; held high from sort completion until the next accepted start or rst.
- swap_count  output  CNT_WIDTH  swaps performed in the last or current sort; saturates at all-ones.

## Operation
- FSM states are IDLE, CMP, SWAP, PASS_END and DONE. DONE behaves exactly like IDLE, except that eoc=1.
- Internal registers:
  - i, the pass index;
  - j, the compare index;
  - swapped, set if any swap occurred in the current pass;
  - mode, the latched descending input.
- IDLE/DONE:
  - wr_en=1 and wr_addr<DEPTH: the write is performed. Writes to wr_addr>=DEPTH are dropped.
  - start=1: go to CMP and set i=0, j=0, swapped=0, swap_count=0, eoc=0, mode=descending.
- CMP compares a=mem[j] with b=mem[j+1]. The pair is out of order when a>b in ascending mode, or a<b in descending mode. Comparison is unsigned and strict, so equal elements are never swapped and the sort is stable.
  - Out of order: go to SWAP.
  - In order, j<DEPTH-2-i: increment j and stay in CMP.
  - In order, j=DEPTH-2-i: go to PASS_END.
- SWAP:
  - mem[j]<=b and mem[j+1]<=a, both on the same edge.
  - swapped<=1; swap_count increments unless it is saturated.
  - Then increment j and return to CMP, or go to PASS_END if j=DEPTH-2-i.
- PASS_END:
  - swapped=0 or i=DEPTH-2: go to DONE.
  - Otherwise: i++, j=0, swapped=0, and go to CMP.
- While busy (states CMP, SWAP, PASS_END), wr_en and start are ignored. rd_data still reflects live memory, which may be mid-sort.

## Timing
- Reset values: state=IDLE, busy=0, eoc=0, swap_count=0, i=j=0, swapped=0, mode=0, and every mem word = 0. Therefore rd_data=0 after reset.
- rst asserted in any state aborts the sort at that edge and applies the reset values above. rst has priority over wr_en and start.
- busy=1 from the edge that accepts start until the edge that enters DONE.
- Per-cycle cost:
  - each CMP costs 1 cycle;
  - each SWAP costs 1 cycle;
  - each pass costs 1 extra cycle for PASS_END.
- Latency, counted in cycles from the accepting edge to eoc=1, is the sum over executed passes of (compares + swaps + 1).
  - Already-sorted input: DEPTH cycles (single pass).
  - Worst case (reverse-ordered input) is bounded by DEPTH*(DEPTH-1) + DEPTH-1 cycles.
- wr_en and start in the same IDLE cycle: the write lands on that edge, and the first CMP (next cycle) sees the new data.
- start while eoc=1: eoc falls on the accepting edge.
- start held high continuously: a new sort is accepted on the first cycle in DONE.
- swap_count is stable from eoc=1 until the next accepted start.

## Test plan
- Reset and readback: assert rst for 2 cycles, then read addresses 0..7. Required: rd_data=0 everywhere, busy=0, eoc=0.
- Already sorted, early exit: load 2,3,4,5,6,7,8,9 (matching the original datapath bench) and pulse start. Required:
  - busy for exactly 8 cycles, then eoc=1;
  - swap_count=0;
  - contents unchanged.
- Reverse order, ascending: load 9,8,7,6,5,4,3,2 with descending=0 and pulse start. Required:
  - readback 2..9;
  - swap_count=28;
  - eoc held until the next start.
- Descending mode with duplicates: load 3,1,3,2,0,2,1,0 with descending=1. Required:
  - readback 3,3,2,2,1,1,0,0;
  - a second start with descending=1 gives swap_count=0.
- Protocol collisions:
  - wr_en to address 0 with value 16'hFFFF while busy: ignored, and the final sort result does not contain FFFF.
  - start pulsed while busy: no restart, and latency is unchanged.
  - wr_en and start in the same IDLE cycle: the new value is included in the sort.
- Reset mid-sort and minimum depth:
  - rst 5 cycles into a reverse-order sort: busy=0, eoc=0, and all memory reads 0 on the next cycle.
  - Separate DEPTH=2, ADDR_WIDTH=1 instance loaded with 5,1: result 1,5, swap_count=1, eoc after 3 cycles.

Source files
------------

// File: rtl/bubble_sort_engine.sv
// In-place bubble sort over an internal register array: load through a write port,
// sort on start (ascending or descending, early exit on a swap-free pass), read back combinationally.
module bubble_sort_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_start,
  input  logic                  i_descending,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_busy,
  output logic                  o_eoc,
  output logic [CNT_WIDTH-1:0]  o_swap_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_SWAP,
    S_PASS_END,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 2);

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_i;
  logic [ADDR_WIDTH-1:0] r_j;
  logic                  r_swapped;
  logic                  r_mode;
  logic [CNT_WIDTH-1:0]  r_swap_count;

  logic [ADDR_WIDTH-1:0] w_j_next;
  logic [ADDR_WIDTH-1:0] w_last_j;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic                  w_out_of_order;
  logic                  w_last_cmp;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_swap;
  logic                  w_j_inc;
  logic                  w_new_pass;

  // Address range guards only exist when DEPTH leaves part of the address space unused.
  if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
    assign w_wr_in_range = 1'b1;
    assign w_rd_in_range = 1'b1;
  end else begin : g_partial_range
    assign w_wr_in_range = (32'(i_wr_addr) < DEPTH);
    assign w_rd_in_range = (32'(i_rd_addr) < DEPTH);
  end

  assign w_j_next       = r_j + 1'b1;
  assign w_last_j       = LAST_IDX - r_i;
  assign w_a            = r_mem[r_j];
  assign w_b            = r_mem[w_j_next];
  assign w_out_of_order = r_mode ? (w_a < w_b) : (w_a > w_b);
  assign w_last_cmp     = (r_j == w_last_j);

  assign o_rd_data    = w_rd_in_range ? r_mem[i_rd_addr] : '0;
  assign o_busy       = (r_state == S_CMP) || (r_state == S_SWAP) || (r_state == S_PASS_END);
  assign o_eoc        = (r_state == S_DONE);
  assign o_swap_count = r_swap_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_swap       = 1'b0;
    w_j_inc      = 1'b0;
    w_new_pass   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        w_load = i_wr_en && w_wr_in_range;
        if (i_start) begin
          w_accept     = 1'b1;
          w_next_state = S_CMP;
        end
      end
      S_CMP: begin
        if (w_out_of_order) begin
          w_next_state = S_SWAP;
        end else if (w_last_cmp) begin
          w_next_state = S_PASS_END;
        end else begin
          w_j_inc = 1'b1;
        end
      end
      S_SWAP: begin
        w_swap = 1'b1;
        if (w_last_cmp) begin
          w_next_state = S_PASS_END;
        end else begin
          w_j_inc      = 1'b1;
          w_next_state = S_CMP;
        end
      end
      S_PASS_END: begin
        if (!r_swapped || (r_i == LAST_IDX)) begin
          w_next_state = S_DONE;
        end else begin
          w_new_pass   = 1'b1;
          w_next_state = S_CMP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: the memory is reset word by word because rd_data must read zero after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
      r_i          <= '0;
      r_j          <= '0;
      r_swapped    <= 1'b0;
      r_mode       <= 1'b0;
      r_swap_count <= '0;
    end else begin
      if (w_load) begin
        r_mem[i_wr_addr] <= i_wr_data;
      end
      if (w_accept) begin
        r_i          <= '0;
        r_j          <= '0;
        r_swapped    <= 1'b0;
        r_mode       <= i_descending;
        r_swap_count <= '0;
      end
      if (w_swap) begin
        r_mem[r_j]      <= w_b;
        r_mem[w_j_next] <= w_a;
        r_swapped       <= 1'b1;
        if (r_swap_count != '1) begin
          r_swap_count <= r_swap_count + 1'b1;
        end
      end
      if (w_j_inc) begin
        r_j <= w_j_next;
      end
      if (w_new_pass) begin
        r_i       <= r_i + 1'b1;
        r_j       <= '0;
        r_swapped <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Scoreboard bench for bubble_sort_engine: stimulus pushes expected results, a monitor
// pops them on each end-of-conversion (or snapshot request) and compares latency, count and memory.
`timescale 1ns/1ps
module tb_bubble_sort_engine;

  typedef logic [7:0][15:0] vec_t;

  typedef struct {
    bit   is_snap;
    int   id;
    int   lat;
    int   swaps;
    bit   busy;
    bit   eoc;
    vec_t mem;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic        descending = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        busy;
  logic        eoc;
  logic [15:0] swap_count;

  logic        d2_wr_en = 1'b0;
  logic [0:0]  d2_wr_addr = '0;
  logic [15:0] d2_wr_data = '0;
  logic        d2_start = 1'b0;
  logic        d2_desc = 1'b0;
  logic [0:0]  d2_rd_addr = '0;
  logic [15:0] d2_rd_data;
  logic        d2_busy;
  logic        d2_eoc;
  logic [15:0] d2_swap_count;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   snap_reqs = 0;
  int   snap_done = 0;

  always #10 clk = ~clk;

  bubble_sort_engine #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_start(start), .i_descending(descending), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_busy(busy), .o_eoc(eoc), .o_swap_count(swap_count)
  );

  bubble_sort_engine #(.DATA_WIDTH(16), .DEPTH(2), .ADDR_WIDTH(1), .CNT_WIDTH(16)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(d2_wr_en), .i_wr_addr(d2_wr_addr), .i_wr_data(d2_wr_data),
    .i_start(d2_start), .i_descending(d2_desc), .i_rd_addr(d2_rd_addr), .o_rd_data(d2_rd_data),
    .o_busy(d2_busy), .o_eoc(d2_eoc), .o_swap_count(d2_swap_count)
  );

  task automatic check(input string name, input int id, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (case %0d): got %0h, expected %0h", name, id, got, exp);
    end
  endtask

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int a4, input int a5, input int a6, input int a7);
    vec_t v;
    v[0] = 16'(a0); v[1] = 16'(a1); v[2] = 16'(a2); v[3] = 16'(a3);
    v[4] = 16'(a4); v[5] = 16'(a5); v[6] = 16'(a6); v[7] = 16'(a7);
    return v;
  endfunction

  // ---------------- monitor ----------------
  task automatic compare_mem(input int id, input vec_t m);
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      #1;
      check($sformatf("mem[%0d]", k), id, 32'(rd_data), 32'(m[k]));
    end
  endtask

  task automatic handle(input bit snap, input int lat);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("unexpected_output", 0, 32'(1), 32'(0));
      return;
    end
    e = sb_q.pop_front();
    check("kind", e.id, 32'(snap), 32'(e.is_snap));
    if (snap) begin
      check("busy", e.id, 32'(busy), 32'(e.busy));
      check("eoc", e.id, 32'(eoc), 32'(e.eoc));
    end else begin
      check("latency", e.id, 32'(lat), 32'(e.lat));
    end
    check("swap_count", e.id, 32'(swap_count), 32'(e.swaps));
    compare_mem(e.id, e.mem);
  endtask

  initial begin
    logic prev_busy;
    logic prev_eoc;
    int   lat;
    prev_busy = 1'bx;
    prev_eoc  = 1'bx;
    lat       = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && prev_busy !== 1'b1) lat = 0;
      if (busy === 1'b1) lat++;
      if (eoc === 1'b1 && prev_eoc === 1'b0) begin
        handle(1'b0, lat);
      end else if (snap_reqs != snap_done) begin
        snap_done++;
        handle(1'b1, 0);
      end
      prev_busy = busy;
      prev_eoc  = eoc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input vec_t v);
    for (int k = 0; k < 8; k++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(k);
      wr_data = v[k];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic desc);
    start      = 1'b1;
    descending = desc;
    tick();
    start = 1'b0;
  endtask

  task automatic push_result(input int id, input int lat, input int swaps, input vec_t m);
    exp_t e;
    e.is_snap = 1'b0; e.id = id; e.lat = lat; e.swaps = swaps;
    e.busy = 1'b0; e.eoc = 1'b1; e.mem = m;
    sb_q.push_back(e);
  endtask

  task automatic request_snap(input int id, input bit b, input bit c, input int swaps,
                              input vec_t m);
    exp_t e;
    e.is_snap = 1'b1; e.id = id; e.lat = 0; e.swaps = swaps;
    e.busy = b; e.eoc = c; e.mem = m;
    sb_q.push_back(e);
    snap_reqs++;
    tick();
    tick();
  endtask

  task automatic wait_done(input int id, input int budget);
    int n;
    n = 0;
    while (eoc !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("done_before_timeout", id, 32'(eoc === 1'b1), 32'(1));
    tick();
    tick();
  endtask

  initial begin
    vec_t zeros;
    vec_t asc;
    vec_t rev;
    vec_t dsc;
    int   n;
    zeros = mk(0, 0, 0, 0, 0, 0, 0, 0);
    asc   = mk(2, 3, 4, 5, 6, 7, 8, 9);
    rev   = mk(9, 8, 7, 6, 5, 4, 3, 2);
    dsc   = mk(3, 3, 2, 2, 1, 1, 0, 0);

    // Reset and readback
    tick();
    tick();
    rst = 1'b0;
    request_snap(1, 1'b0, 1'b0, 0, zeros);

    // Already sorted: one pass, no swaps
    load(asc);
    push_result(2, 8, 0, asc);
    pulse_start(1'b0);
    wait_done(2, 200);

    // Reverse order ascending, then eoc must stay high while idle
    load(rev);
    push_result(3, 63, 28, asc);
    pulse_start(1'b0);
    wait_done(3, 200);
    repeat (3) tick();
    request_snap(4, 1'b0, 1'b1, 28, asc);

    // Descending with duplicates, then re-sort of the already-sorted result
    load(mk(3, 1, 3, 2, 0, 2, 1, 0));
    push_result(5, 26, 5, dsc);
    pulse_start(1'b1);
    wait_done(5, 200);
    push_result(6, 8, 0, dsc);
    pulse_start(1'b1);
    wait_done(6, 200);

    // Write and start while busy are ignored
    load(rev);
    push_result(7, 63, 28, asc);
    pulse_start(1'b0);
    repeat (3) tick();
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 16'hFFFF;
    start   = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    wait_done(7, 200);

    // Write and start on the same idle edge: the new value takes part in the sort
    push_result(8, 42, 7, mk(0, 2, 3, 4, 5, 6, 7, 8));
    wr_en      = 1'b1;
    wr_addr    = 3'd7;
    wr_data    = 16'd0;
    start      = 1'b1;
    descending = 1'b0;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    wait_done(8, 200);

    // Reset in the middle of a sort
    load(rev);
    pulse_start(1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    request_snap(9, 1'b0, 1'b0, 0, zeros);

    // Minimum depth instance
    d2_wr_en   = 1'b1;
    d2_wr_addr = 1'b0;
    d2_wr_data = 16'd5;
    tick();
    d2_wr_addr = 1'b1;
    d2_wr_data = 16'd1;
    tick();
    d2_wr_en = 1'b0;
    d2_start = 1'b1;
    tick();
    d2_start = 1'b0;
    n = 0;
    while (d2_eoc !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("d2_latency", 10, 32'(n), 32'(3));
    check("d2_swap_count", 10, 32'(d2_swap_count), 32'(1));
    d2_rd_addr = 1'b0;
    #1;
    check("d2_mem[0]", 10, 32'(d2_rd_data), 32'(1));
    d2_rd_addr = 1'b1;
    #1;
    check("d2_mem[1]", 10, 32'(d2_rd_data), 32'(5));

    repeat (4) tick();
    check("scoreboard_drained", 0, 32'(sb_q.size()), 32'(0));
    check("snapshots_served", 0, 32'(snap_done), 32'(snap_reqs));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
